// File: rtl/input_sync_bank.sv
// input_sync_bank: per-channel synchroniser, debouncer and edge-pulse generator
// with optional re-trigger holdoff and combinational pulse summary outputs.
module input_sync_bank #(
   parameter int unsigned N               = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned HOLDOFF_CYCLES  = 0,
   parameter int unsigned EDGE_MODE       = 0,
   parameter logic        IDLE_LEVEL      = 1'b1,
   localparam int unsigned IW             = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  async_in,
   output logic [N-1:0]  level_s,
   output logic [N-1:0]  pulse,
   output logic          any_pulse,
   output logic          multi_pulse,
   output logic [IW-1:0] pulse_idx
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);

   logic [SYNC_STAGES-1:0] sync_r  [N];
   logic [CW-1:0]          cnt     [N];
   logic [HW-1:0]          holdoff [N];
   logic [N-1:0]           sync_q;
   logic [N-1:0]           lvl;
   logic [N-1:0]           edge_ok_c;
   logic [N-1:0]           accept_c;
   logic [N-1:0]           fire_c;
   logic                   seen_c;

   // Last synchroniser stage is the only view of the input the debouncer uses
   always_comb begin
      sync_q = '0;
      for (int i = 0; i < int'(N); i++) begin
         sync_q[i] = sync_r[i][SYNC_STAGES-1];
      end
   end

   // Which newly accepted levels count as an event for the configured edge mode
   assign edge_ok_c = (EDGE_MODE == 0) ? ~sync_q :
                      (EDGE_MODE == 1) ?  sync_q : {N{1'b1}};

   // Acceptance on the edge where the counter would reach DEBOUNCE_CYCLES; pulse only outside holdoff
   always_comb begin
      accept_c = '0;
      fire_c   = '0;
      for (int i = 0; i < int'(N); i++) begin
         accept_c[i] = (sync_q[i] != lvl[i]) && (cnt[i] == CNT_LAST);
         fire_c[i]   = accept_c[i] && edge_ok_c[i] && (holdoff[i] == '0);
      end
   end

   // Synchroniser chains, shifting the raw input in at stage 0
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(N); i++) begin
         if (rst) begin
            sync_r[i] <= {SYNC_STAGES{IDLE_LEVEL}};
         end else begin
            sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], async_in[i]};
         end
      end
   end

   // Debounce counters and accepted levels; counter never passes CNT_LAST so it cannot wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         lvl <= {N{IDLE_LEVEL}};
         for (int i = 0; i < int'(N); i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(N); i++) begin
            if (sync_q[i] == lvl[i]) begin
               cnt[i] <= '0;
            end else if (accept_c[i]) begin
               cnt[i] <= '0;
               lvl[i] <= sync_q[i];
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   // Registered pulses and holdoff lockout; holdoff only reloads when a pulse is actually emitted
   always_ff @(posedge clk) begin
      if (rst) begin
         pulse <= '0;
         for (int i = 0; i < int'(N); i++) begin
            holdoff[i] <= '0;
         end
      end else begin
         pulse <= fire_c;
         for (int i = 0; i < int'(N); i++) begin
            if (fire_c[i]) begin
               holdoff[i] <= HOLD_LOAD;
            end else if (holdoff[i] != '0) begin
               holdoff[i] <= holdoff[i] - HW'(1);
            end
         end
      end
   end

   assign level_s   = lvl;
   assign any_pulse = |pulse;

   // Lowest active pulse index and two-or-more detection from the registered pulse vector
   always_comb begin
      seen_c      = 1'b0;
      multi_pulse = 1'b0;
      pulse_idx   = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (pulse[i]) begin
            if (seen_c) begin
               multi_pulse = 1'b1;
            end else begin
               pulse_idx = IW'(i);
            end
            seen_c = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_input_sync_bank.sv
// Testbench for input_sync_bank: directed vector table, hand sequences for holdoff
// and minimal-configuration latency, and randomized traffic against a reference model.
module tb_input_sync_bank;

   typedef struct {
      logic       rst;
      logic [3:0] in;
      logic [3:0] lvl;
      logic [3:0] pul;
      logic       any;
      logic       multi;
      logic [1:0] idx;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: all defaults
   logic       rst_a;
   logic [3:0] in_a, lvl_a, pul_a;
   logic       any_a, multi_a;
   logic [1:0] idx_a;
   // Instance B: holdoff 20, both edges
   logic       rst_b;
   logic [3:0] in_b, lvl_b, pul_b;
   logic       any_b, multi_b;
   logic [1:0] idx_b;
   // Instance C: single channel, 3 stages, debounce 1, rising, idle low
   logic       rst_c;
   logic [0:0] in_c, lvl_c, pul_c, idx_c;
   logic       any_c, multi_c;

   input_sync_bank dut_a (
      .clk(clk), .rst(rst_a), .async_in(in_a), .level_s(lvl_a), .pulse(pul_a),
      .any_pulse(any_a), .multi_pulse(multi_a), .pulse_idx(idx_a));

   input_sync_bank #(.HOLDOFF_CYCLES(20), .EDGE_MODE(2)) dut_b (
      .clk(clk), .rst(rst_b), .async_in(in_b), .level_s(lvl_b), .pulse(pul_b),
      .any_pulse(any_b), .multi_pulse(multi_b), .pulse_idx(idx_b));

   input_sync_bank #(.N(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .EDGE_MODE(1),
                     .IDLE_LEVEL(1'b0)) dut_c (
      .clk(clk), .rst(rst_c), .async_in(in_c), .level_s(lvl_c), .pulse(pul_c),
      .any_pulse(any_c), .multi_pulse(multi_c), .pulse_idx(idx_c));

   int checks = 0;
   int errors = 0;

   vec_t vecs[$];

   // Reference model state for instances A (m=0) and B (m=1)
   int m_pipe  [2][4][4];
   int m_lvl   [2][4];
   int m_run   [2][4];
   int m_since [2][4];
   int m_pulse [2][4];
   int cfg_ss   [2] = '{2, 2};
   int cfg_deb  [2] = '{4, 4};
   int cfg_hold [2] = '{0, 20};
   int cfg_mode [2] = '{0, 2};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic r, input logic [3:0] i, input logic [3:0] l,
                               input logic [3:0] p, input logic an, input logic mu,
                               input logic [1:0] ix);
      vec_t v;
      v.rst = r; v.in = i; v.lvl = l; v.pul = p; v.any = an; v.multi = mu; v.idx = ix;
      vecs.push_back(v);
   endfunction

   // One clock edge of the model: delayed input view, level accepted after a
   // sustained mismatch, pulse if edge matches and enough edges since last pulse
   function automatic void model_step(input int m, input logic r, input logic [3:0] a);
      for (int ch = 0; ch < 4; ch++) begin
         int sq;
         bit acc;
         bit match;
         if (r) begin
            for (int k = 0; k < 4; k++) m_pipe[m][ch][k] = 1;
            m_lvl[m][ch]   = 1;
            m_run[m][ch]   = 0;
            m_since[m][ch] = 1000;
            m_pulse[m][ch] = 0;
         end else begin
            sq = m_pipe[m][ch][cfg_ss[m]-1];
            for (int k = cfg_ss[m] - 1; k > 0; k--) m_pipe[m][ch][k] = m_pipe[m][ch][k-1];
            m_pipe[m][ch][0] = a[ch] ? 1 : 0;
            acc = 1'b0;
            if (sq == m_lvl[m][ch]) begin
               m_run[m][ch] = 0;
            end else begin
               m_run[m][ch]++;
               if (m_run[m][ch] >= cfg_deb[m]) begin
                  acc = 1'b1;
                  m_lvl[m][ch] = sq;
                  m_run[m][ch] = 0;
               end
            end
            if (m_since[m][ch] < 1000) m_since[m][ch]++;
            match = (cfg_mode[m] == 2) || (cfg_mode[m] == 1 && sq == 1) ||
                    (cfg_mode[m] == 0 && sq == 0);
            m_pulse[m][ch] = (acc && match && m_since[m][ch] > cfg_hold[m]) ? 1 : 0;
            if (m_pulse[m][ch] != 0) m_since[m][ch] = 0;
         end
      end
   endfunction

   task automatic check_model(input int m, input logic [3:0] lvl, input logic [3:0] pul,
                              input logic an, input logic mu, input logic [1:0] ix);
      logic [3:0] el;
      logic [3:0] ep;
      int n;
      int first;
      n = 0;
      first = -1;
      for (int ch = 0; ch < 4; ch++) begin
         el[ch] = (m_lvl[m][ch] != 0);
         ep[ch] = (m_pulse[m][ch] != 0);
         if (ep[ch]) begin
            n++;
            if (first < 0) first = ch;
         end
      end
      check($sformatf("rand%0d_level", m), 32'(lvl), 32'(el));
      check($sformatf("rand%0d_pulse", m), 32'(pul), 32'(ep));
      check($sformatf("rand%0d_any", m), 32'(an), 32'(n > 0));
      check($sformatf("rand%0d_multi", m), 32'(mu), 32'(n > 1));
      check($sformatf("rand%0d_idx", m), 32'(ix), (first < 0) ? 32'd0 : 32'(first));
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      in_a = 4'hF; in_b = 4'hF; in_c = 1'b0;

      // Directed table for instance A
      add(1, 4'hF, 4'hF, 4'h0, 0, 0, 0);
      add(1, 4'hF, 4'hF, 4'h0, 0, 0, 0);
      for (int s = 1; s <= 7; s++) begin
         if (s < 6)       add(0, 4'hB, 4'hF, 4'h0, 0, 0, 0);
         else if (s == 6) add(0, 4'hB, 4'hB, 4'h4, 1, 0, 2);
         else             add(0, 4'hB, 4'hB, 4'h0, 0, 0, 0);
      end
      for (int s = 1; s <= 7; s++) begin
         if (s < 6)       add(0, 4'h1, 4'hB, 4'h0, 0, 0, 0);
         else if (s == 6) add(0, 4'h1, 4'h1, 4'hA, 1, 1, 1);
         else             add(0, 4'h1, 4'h1, 4'h0, 0, 0, 0);
      end
      for (int s = 0; s < 3; s++) add(0, 4'h0, 4'h1, 4'h0, 0, 0, 0);
      for (int s = 0; s < 8; s++) add(0, 4'h1, 4'h1, 4'h0, 0, 0, 0);
      add(1, 4'hF, 4'hF, 4'h0, 0, 0, 0);
      add(1, 4'hF, 4'hF, 4'h0, 0, 0, 0);
      for (int s = 1; s <= 4; s++) add(0, 4'hE, 4'hF, 4'h0, 0, 0, 0);
      add(1, 4'hE, 4'hF, 4'h0, 0, 0, 0);
      for (int s = 1; s <= 7; s++) begin
         if (s < 6)       add(0, 4'hE, 4'hF, 4'h0, 0, 0, 0);
         else if (s == 6) add(0, 4'hE, 4'hE, 4'h1, 1, 0, 0);
         else             add(0, 4'hE, 4'hE, 4'h0, 0, 0, 0);
      end

      foreach (vecs[k]) begin
         rst_a = vecs[k].rst;
         in_a  = vecs[k].in;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_level", k), 32'(lvl_a), 32'(vecs[k].lvl));
         check($sformatf("vec%0d_pulse", k), 32'(pul_a), 32'(vecs[k].pul));
         check($sformatf("vec%0d_any", k), 32'(any_a), 32'(vecs[k].any));
         check($sformatf("vec%0d_multi", k), 32'(multi_a), 32'(vecs[k].multi));
         check($sformatf("vec%0d_idx", k), 32'(idx_a), 32'(vecs[k].idx));
      end

      // Instance C: rising edge with debounce 1 after 3 sync stages
      rst_c = 1'b1; in_c = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("c_reset_level", 32'(lvl_c), 32'd0);
      check("c_reset_pulse", 32'(pul_c), 32'd0);
      rst_c = 1'b0; in_c = 1'b1;
      for (int s = 1; s <= 6; s++) begin
         @(posedge clk);
         #1;
         check($sformatf("c_s%0d_pulse", s), 32'(pul_c), 32'(s == 4));
         check($sformatf("c_s%0d_level", s), 32'(lvl_c), 32'(s >= 4));
         check($sformatf("c_s%0d_any", s), 32'(any_c), 32'(s == 4));
         check($sformatf("c_s%0d_idx", s), 32'(idx_c), 32'd0);
         check($sformatf("c_s%0d_multi", s), 32'(multi_c), 32'd0);
      end

      // Instance B: changes accepted at edges 6, 18, 30; second falls inside holdoff
      rst_b = 1'b1; in_b = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      rst_b = 1'b0;
      for (int s = 1; s <= 35; s++) begin
         logic b0;
         logic l0;
         logic p0;
         b0 = (s < 13) ? 1'b0 : (s < 25) ? 1'b1 : 1'b0;
         in_b = {3'b111, b0};
         l0 = (s < 6) ? 1'b1 : (s < 18) ? 1'b0 : (s < 30) ? 1'b1 : 1'b0;
         p0 = (s == 6) || (s == 30);
         @(posedge clk);
         #1;
         check($sformatf("b_s%0d_level", s), 32'(lvl_b), 32'({3'b111, l0}));
         check($sformatf("b_s%0d_pulse", s), 32'(pul_b), 32'({3'b000, p0}));
         check($sformatf("b_s%0d_any", s), 32'(any_b), 32'(p0));
      end

      // Randomized traffic on A and B against the reference model
      for (int s = 0; s < 3000; s++) begin
         rst_a = (s < 2) || ($urandom_range(0, 199) == 0);
         rst_b = (s < 2) || ($urandom_range(0, 199) == 0);
         for (int ch = 0; ch < 4; ch++) begin
            if ($urandom_range(0, 9) == 0) in_a[ch] = ~in_a[ch];
            if ($urandom_range(0, 9) == 0) in_b[ch] = ~in_b[ch];
         end
         @(posedge clk);
         #1;
         model_step(0, rst_a, in_a);
         model_step(1, rst_b, in_b);
         check_model(0, lvl_a, pul_a, any_a, multi_a, idx_a);
         check_model(1, lvl_b, pul_b, any_b, multi_b, idx_b);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
